// File: rtl/memory_access_stage_pkg.sv
// Shared pipeline types for the memory-access stage: rd control, memory
// operation and size encodings, FSM state, and the alignment rule.
package memory_access_stage_pkg;

    typedef struct packed {
        logic       wEnable;
        logic [4:0] addr;
    } RDCtrl;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } MemOp;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } MemSize;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } MemState;

    localparam RDCtrl RD_CTRL_NONE = '{wEnable: 1'b0, addr: 5'd0};

    // Halfwords need an even address, words (and the unused encoding) need
    // a 4-byte aligned address; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (MemSize'(size))
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = off[0];
            default:   bad = (off != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: store data replication and byte strobes, load
// extraction with sign/zero extension, and the misalignment check.
module load_store_align
    import memory_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_word,
    output logic [XLEN-1:0] wdata,
    output logic [3:0]      strb,
    output logic [XLEN-1:0] load_value,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted_s;

    assign shifted_s  = load_word >> {addr_lo, 3'b000};
    assign misaligned = is_misaligned(size, addr_lo);

    // Store lanes: replicate narrow data across the word and pick strobes
    always_comb begin
        wdata = store_data;
        strb  = 4'b1111;
        case (MemSize'(size))
            SIZE_BYTE: begin
                wdata = {(XLEN/8){store_data[7:0]}};
                strb  = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata = {(XLEN/16){store_data[15:0]}};
                strb  = 4'b0011 << addr_lo;
            end
            default: begin
                wdata = store_data;
                strb  = 4'b1111;
            end
        endcase
    end

    // Load extract: take the low lane of the shifted word and extend it
    always_comb begin
        load_value = shifted_s;
        case (MemSize'(size))
            SIZE_BYTE: begin
                if (is_unsigned) begin
                    load_value = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
                end else begin
                    load_value = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
                end
            end
            SIZE_HALF: begin
                if (is_unsigned) begin
                    load_value = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
                end else begin
                    load_value = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
                end
            end
            default: load_value = shifted_s;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// Memory-access pipeline stage: runs loads/stores over a valid/ready data
// port with a separate response channel, stalls upstream while a transaction
// is outstanding, and fills the write-back pipe register.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inValid,
    input  logic [XLEN-1:0] inAddr,
    input  logic [XLEN-1:0] inStoreData,
    input  logic [1:0]      inMemOp,
    input  logic [1:0]      inSize,
    input  logic            inUnsigned,
    input  RDCtrl           inRdCtrl,
    input  logic            flush,
    output logic            stall,
    output RDCtrl           rdCtrl,
    output logic            dmemReqValid,
    input  logic            dmemReqReady,
    output logic [XLEN-1:0] dmemAddr,
    output logic            dmemWe,
    output logic [XLEN-1:0] dmemWdata,
    output logic [3:0]      dmemStrb,
    input  logic            dmemRespValid,
    input  logic [XLEN-1:0] dmemRdata,
    output logic            misaligned,
    output logic            wbValid,
    output RDCtrl           wbRdCtrl,
    output logic [XLEN-1:0] wbData
);

    MemState         state_r, state_n;
    logic [XLEN-1:0] addr_r, store_data_r;
    logic [1:0]      size_r;
    logic            unsigned_r, is_store_r;
    RDCtrl           rd_r;
    logic            wb_valid_r;
    RDCtrl           wb_rd_r;
    logic [XLEN-1:0] wb_data_r;

    logic [XLEN-1:0] cur_addr_s, cur_store_data_s;
    logic [1:0]      cur_size_s;
    logic            cur_unsigned_s, cur_store_s;
    logic [XLEN-1:0] wdata_s, load_value_s;
    logic [3:0]      strb_s;
    logic            misalign_s;
    logic            is_load_s, is_store_s, mem_op_s, start_s, req_s, accept_s;
    logic            complete_s, cmp_valid_s;
    RDCtrl           cmp_rd_s;
    logic [XLEN-1:0] cmp_data_s;

    // Operand select: live inputs while idle, the captured copy once launched
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_addr_s       = inAddr;
            cur_store_data_s = inStoreData;
            cur_size_s       = inSize;
            cur_unsigned_s   = inUnsigned;
            cur_store_s      = is_store_s;
        end else begin
            cur_addr_s       = addr_r;
            cur_store_data_s = store_data_r;
            cur_size_s       = size_r;
            cur_unsigned_s   = unsigned_r;
            cur_store_s      = is_store_r;
        end
    end

    load_store_align #(.XLEN(XLEN)) u_align (
        .addr_lo     (cur_addr_s[1:0]),
        .size        (cur_size_s),
        .is_unsigned (cur_unsigned_s),
        .store_data  (cur_store_data_s),
        .load_word   (dmemRdata),
        .wdata       (wdata_s),
        .strb        (strb_s),
        .load_value  (load_value_s),
        .misaligned  (misalign_s)
    );

    assign is_load_s  = (inMemOp == MEM_LOAD);
    assign is_store_s = (inMemOp == MEM_STORE);
    assign mem_op_s   = inValid && (is_load_s || is_store_s);
    assign start_s    = rst && (state_r == ST_IDLE) && mem_op_s && !flush && !misalign_s;
    assign req_s      = start_s || (rst && (state_r == ST_REQ) && !flush);
    assign accept_s   = req_s && dmemReqReady;

    // Next state and completion: what (if anything) lands in write-back
    always_comb begin
        state_n     = state_r;
        complete_s  = 1'b0;
        cmp_valid_s = 1'b0;
        cmp_rd_s    = RD_CTRL_NONE;
        cmp_data_s  = {XLEN{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    if (accept_s && is_store_s) begin
                        complete_s  = 1'b1;
                        cmp_valid_s = 1'b1;
                        cmp_rd_s    = '{wEnable: 1'b0, addr: inRdCtrl.addr};
                        cmp_data_s  = inAddr;
                    end else if (accept_s) begin
                        state_n = ST_RESP;
                    end else begin
                        state_n = ST_REQ;
                    end
                end else begin
                    // Non-memory op, bubble, flushed op or misaligned access
                    complete_s  = 1'b1;
                    cmp_valid_s = inValid && !flush && !(mem_op_s && misalign_s);
                    cmp_rd_s    = inRdCtrl;
                    cmp_data_s  = inAddr;
                end
            end
            ST_REQ: begin
                if (flush) begin
                    complete_s = 1'b1;
                    state_n    = ST_IDLE;
                end else if (accept_s && is_store_r) begin
                    complete_s  = 1'b1;
                    cmp_valid_s = 1'b1;
                    cmp_rd_s    = '{wEnable: 1'b0, addr: rd_r.addr};
                    cmp_data_s  = addr_r;
                    state_n     = ST_IDLE;
                end else if (accept_s) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_REQ;
                end
            end
            ST_RESP: begin
                if (dmemRespValid) begin
                    complete_s  = 1'b1;
                    cmp_valid_s = !flush;
                    cmp_rd_s    = rd_r;
                    cmp_data_s  = load_value_s;
                    state_n     = ST_IDLE;
                end else if (flush) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_RESP;
                end
            end
            ST_DRAIN: begin
                if (dmemRespValid) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // FSM state plus capture of the operation at launch so the request stays stable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            addr_r       <= {XLEN{1'b0}};
            store_data_r <= {XLEN{1'b0}};
            size_r       <= 2'd0;
            unsigned_r   <= 1'b0;
            is_store_r   <= 1'b0;
            rd_r         <= RD_CTRL_NONE;
        end else begin
            state_r <= state_n;
            if (start_s) begin
                addr_r       <= inAddr;
                store_data_r <= inStoreData;
                size_r       <= inSize;
                unsigned_r   <= inUnsigned;
                is_store_r   <= is_store_s;
                rd_r         <= inRdCtrl;
            end
        end
    end

    // Write-back pipe register: loaded on completion, a bubble while stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_r <= 1'b0;
            wb_rd_r    <= RD_CTRL_NONE;
            wb_data_r  <= {XLEN{1'b0}};
        end else begin
            wb_valid_r <= complete_s && cmp_valid_s;
            if (complete_s) begin
                wb_rd_r   <= cmp_rd_s;
                wb_data_r <= cmp_data_s;
            end
        end
    end

    // Handshake-side outputs are gated by reset so they read zero while it is held
    assign stall        = rst && !complete_s;
    assign dmemReqValid = req_s;
    assign dmemAddr     = {cur_addr_s[XLEN-1:2], 2'b00};
    assign dmemWe       = req_s && cur_store_s;
    assign dmemWdata    = wdata_s;
    assign dmemStrb     = strb_s;
    assign misaligned   = rst && (state_r == ST_IDLE) && mem_op_s && !flush && misalign_s;
    assign rdCtrl       = (rst && inValid) ? inRdCtrl : RD_CTRL_NONE;
    assign wbValid      = wb_valid_r;
    assign wbRdCtrl     = wb_rd_r;
    assign wbData       = wb_data_r;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a write-back scoreboard.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] inAddr, inStoreData;
    logic [1:0]  inMemOp, inSize;
    logic        inUnsigned;
    RDCtrl       inRdCtrl;
    logic        flush;
    logic        stall;
    RDCtrl       rdCtrl;
    logic        dmemReqValid, dmemReqReady;
    logic [31:0] dmemAddr;
    logic        dmemWe;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemStrb;
    logic        dmemRespValid;
    logic [31:0] dmemRdata;
    logic        misaligned;
    logic        wbValid;
    RDCtrl       wbRdCtrl;
    logic [31:0] wbData;

    typedef struct {
        RDCtrl       rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      n_cmp = 0;
    int      n_err = 0;
    int      stall_cnt;

    memory_access_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inAddr(inAddr),
        .inStoreData(inStoreData), .inMemOp(inMemOp), .inSize(inSize),
        .inUnsigned(inUnsigned), .inRdCtrl(inRdCtrl), .flush(flush),
        .stall(stall), .rdCtrl(rdCtrl), .dmemReqValid(dmemReqValid),
        .dmemReqReady(dmemReqReady), .dmemAddr(dmemAddr), .dmemWe(dmemWe),
        .dmemWdata(dmemWdata), .dmemStrb(dmemStrb), .dmemRespValid(dmemRespValid),
        .dmemRdata(dmemRdata), .misaligned(misaligned), .wbValid(wbValid),
        .wbRdCtrl(wbRdCtrl), .wbData(wbData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        inValid = 1'b0; inAddr = 32'd0; inStoreData = 32'd0; inMemOp = 2'd0;
        inSize = 2'd0; inUnsigned = 1'b0; inRdCtrl = '{wEnable: 1'b0, addr: 5'd0};
        flush = 1'b0; dmemReqReady = 1'b0; dmemRespValid = 1'b0; dmemRdata = 32'd0;
    endtask

    // Advance one clock and check the write-back register against the scoreboard
    task automatic tick();
        wb_exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("wb_spurious_valid", 64'(wbValid), 64'd0);
        end else if (wbValid === 1'b1) begin
            e = sb.pop_front();
            chk("wb_data", 64'(wbData), 64'(e.data));
            chk("wb_rdctrl", 64'(wbRdCtrl), 64'(e.rd));
        end
    endtask

    task automatic do_alu(input logic [31:0] res, input logic [4:0] rd);
        inValid = 1'b1; inAddr = res; inMemOp = 2'd0; inRdCtrl = '{wEnable: 1'b1, addr: rd};
        sb.push_back('{rd: '{wEnable: 1'b1, addr: rd}, data: res});
        #4;
        chk("alu_stall", 64'(stall), 64'd0);
        chk("alu_rdctrl", 64'(rdCtrl), 64'({1'b1, rd}));
        chk("alu_no_req", 64'(dmemReqValid), 64'd0);
        tick();
        drive_idle();
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb, input logic [4:0] rd);
        inValid = 1'b1; inAddr = addr; inStoreData = data; inMemOp = 2'd2; inSize = size;
        inRdCtrl = '{wEnable: 1'b1, addr: rd}; dmemReqReady = 1'b1;
        sb.push_back('{rd: '{wEnable: 1'b0, addr: rd}, data: addr});
        #4;
        chk("st_req", 64'(dmemReqValid), 64'd1);
        chk("st_we", 64'(dmemWe), 64'd1);
        chk("st_addr", 64'(dmemAddr), 64'({addr[31:2], 2'b00}));
        chk("st_strb", 64'(dmemStrb), 64'(exp_strb));
        chk("st_wdata", 64'(dmemWdata), 64'(exp_wdata));
        chk("st_stall", 64'(stall), 64'd0);
        tick();
        drive_idle();
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                           input logic [31:0] rdata, input logic [31:0] exp, input logic [4:0] rd);
        inValid = 1'b1; inAddr = addr; inMemOp = 2'd1; inSize = size; inUnsigned = uns;
        inRdCtrl = '{wEnable: 1'b1, addr: rd}; dmemReqReady = 1'b1;
        sb.push_back('{rd: '{wEnable: 1'b1, addr: rd}, data: exp});
        #4;
        chk("ld_req", 64'(dmemReqValid), 64'd1);
        chk("ld_we", 64'(dmemWe), 64'd0);
        chk("ld_stall_wait", 64'(stall), 64'd1);
        tick();
        dmemReqReady = 1'b0; dmemRespValid = 1'b1; dmemRdata = rdata;
        #4;
        chk("ld_stall_done", 64'(stall), 64'd0);
        chk("ld_req_dropped", 64'(dmemReqValid), 64'd0);
        tick();
        drive_idle();
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        #8;
        chk("rst_wbvalid", 64'(wbValid), 64'd0);
        chk("rst_wbdata", 64'(wbData), 64'd0);
        chk("rst_wbrd", 64'(wbRdCtrl), 64'd0);
        chk("rst_req", 64'(dmemReqValid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_misaligned", 64'(misaligned), 64'd0);
        #4;
        rst = 1'b1;
        tick();

        // ALU result passes straight through
        do_alu(32'h0000_1234, 5'd5);
        tick();

        // Stores with lane replication and strobes
        do_store(32'h0000_1003, 2'd0, 32'h1234_56AB, 32'hABAB_ABAB, 4'b1000, 5'd7);
        do_store(32'h0000_1002, 2'd1, 32'h0000_BEEF, 32'hBEEF_BEEF, 4'b1100, 5'd8);
        do_store(32'h0000_2004, 2'd2, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111, 5'd9);

        // Loads with extraction and extension
        do_load(32'h0000_1002, 2'd0, 1'b0, 32'h0080_0000, 32'hFFFF_FF80, 5'd10);
        do_load(32'h0000_1002, 2'd0, 1'b1, 32'h0080_0000, 32'h0000_0080, 5'd11);
        do_load(32'h0000_1002, 2'd1, 1'b0, 32'h8001_0000, 32'hFFFF_8001, 5'd13);

        // LW: ready low for 3 cycles, response 2 cycles after acceptance
        inValid = 1'b1; inAddr = 32'h0000_2000; inMemOp = 2'd1; inSize = 2'd2; inUnsigned = 1'b0;
        inRdCtrl = '{wEnable: 1'b1, addr: 5'd12}; dmemRdata = 32'hDEAD_BEEF;
        sb.push_back('{rd: '{wEnable: 1'b1, addr: 5'd12}, data: 32'hDEAD_BEEF});
        stall_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            dmemReqReady  = (c == 3);
            dmemRespValid = (c == 5);
            #4;
            if (stall === 1'b1) stall_cnt++;
            if (c <= 3) begin
                chk("lw_req_held", 64'(dmemReqValid), 64'd1);
                chk("lw_addr_held", 64'(dmemAddr), 64'h2000);
            end
            tick();
        end
        chk("lw_stall_cycles", 64'(stall_cnt), 64'd5);
        drive_idle();

        // Misaligned halfword load
        inValid = 1'b1; inAddr = 32'h0000_1001; inMemOp = 2'd1; inSize = 2'd1;
        inRdCtrl = '{wEnable: 1'b1, addr: 5'd6}; dmemReqReady = 1'b1;
        #4;
        chk("mis_pulse", 64'(misaligned), 64'd1);
        chk("mis_no_req", 64'(dmemReqValid), 64'd0);
        chk("mis_stall", 64'(stall), 64'd0);
        tick();
        chk("mis_wbvalid", 64'(wbValid), 64'd0);
        drive_idle();
        #4;
        chk("mis_pulse_end", 64'(misaligned), 64'd0);
        tick();

        // Load flushed while its response is pending
        inValid = 1'b1; inAddr = 32'h0000_3000; inMemOp = 2'd1; inSize = 2'd2;
        inRdCtrl = '{wEnable: 1'b1, addr: 5'd15}; dmemReqReady = 1'b1;
        #4;
        chk("fl_accept_stall", 64'(stall), 64'd1);
        tick();
        dmemReqReady = 1'b0; flush = 1'b1;
        #4;
        chk("fl_resp_stall", 64'(stall), 64'd1);
        tick();
        flush = 1'b0; inValid = 1'b0; inMemOp = 2'd0;
        #4;
        chk("fl_drain_stall", 64'(stall), 64'd1);
        chk("fl_drain_noreq", 64'(dmemReqValid), 64'd0);
        tick();
        dmemRespValid = 1'b1; dmemRdata = 32'h1111_1111;
        #4;
        chk("fl_drain_resp_stall", 64'(stall), 64'd1);
        tick();
        chk("fl_wbvalid", 64'(wbValid), 64'd0);
        drive_idle();
        do_alu(32'h0000_0055, 5'd3);

        // Reset asserted while a load response is pending
        inValid = 1'b1; inAddr = 32'h0000_4000; inMemOp = 2'd1; inSize = 2'd2;
        inRdCtrl = '{wEnable: 1'b1, addr: 5'd14}; dmemReqReady = 1'b1;
        #4;
        tick();
        dmemReqReady = 1'b0; rst = 1'b0;
        #4;
        chk("mrst_stall", 64'(stall), 64'd0);
        chk("mrst_req", 64'(dmemReqValid), 64'd0);
        chk("mrst_misaligned", 64'(misaligned), 64'd0);
        chk("mrst_wbvalid", 64'(wbValid), 64'd0);
        chk("mrst_wbdata", 64'(wbData), 64'd0);
        chk("mrst_wbrd", 64'(wbRdCtrl), 64'd0);
        chk("mrst_rdctrl", 64'(rdCtrl), 64'd0);
        tick();
        drive_idle();
        rst = 1'b1;
        tick();
        do_alu(32'h0000_0077, 5'd4);
        tick();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
